// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Registers come out of reset holding their own index.
package regfile_pkg;

  localparam int DEFAULT_DEPTH  = 15;
  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_NUM_RD = 3;
  localparam int DEFAULT_PEND_W = 2;

  typedef logic [DEFAULT_PEND_W-1:0] pend_cnt_t;

  function automatic int unsigned reset_value(input int unsigned idx);
    return idx;
  endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Issue, writeback, flush and read-port bundle of the scoreboarded register file.
interface register_file_sb_if
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_RD = DEFAULT_NUM_RD
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic                    iss_valid;
  logic [AW-1:0]           iss_dest;
  logic                    iss_ready;
  logic                    wb_en;
  logic [AW-1:0]           wb_dest;
  logic [WIDTH-1:0]        wb_value;
  logic                    flush;

  modport master (
    output rd_addr, iss_valid, iss_dest, wb_en, wb_dest, wb_value, flush,
    input  rd_data, rd_busy, iss_ready
  );

  modport slave (
    input  rd_addr, iss_valid, iss_dest, wb_en, wb_dest, wb_value, flush,
    output rd_data, rd_busy, iss_ready
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, data mux and busy decode.
// With REGFILE_WB_BYPASS_EN defined, a same-cycle writeback is forwarded.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int PEND_W = DEFAULT_PEND_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0]     addr,
  input  logic [WIDTH-1:0]  mem [DEPTH],
  input  logic [PEND_W-1:0] cnt [DEPTH],
`ifdef REGFILE_WB_BYPASS_EN
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_dest,
  input  logic [WIDTH-1:0]  wb_value,
`endif
  output logic [WIDTH-1:0]  data,
  output logic              busy
);

  logic in_range;

  assign in_range = ({{(32-AW){1'b0}}, addr} < 32'(DEPTH));

  always_comb begin
    data = '0;
    busy = 1'b0;
    if (in_range) begin
      data = mem[addr];
      busy = (cnt[addr] != '0);
`ifdef REGFILE_WB_BYPASS_EN
      // The write landing this cycle resolves one of the pending reservations.
      if (wb_en && (wb_dest == addr)) begin
        data = wb_value;
        busy = (cnt[addr] > PEND_W'(1));
      end
`endif
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Register file with NUM_RD read ports, one writeback port and a per-register
// pending-write scoreboard. Optional same-cycle bypass: REGFILE_WB_BYPASS_EN.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_RD = DEFAULT_NUM_RD,
  parameter int PEND_W = DEFAULT_PEND_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  register_file_sb_if.slave bus
);

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [PEND_W-1:0]       cnt [DEPTH];
  logic [NUM_RD*WIDTH-1:0] rd_data_w;
  logic [NUM_RD-1:0]       rd_busy_w;
  logic                    iss_ready_w;
  logic                    fire;

  // Out-of-range destinations match no entry and so are never ready.
  always_comb begin
    iss_ready_w = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.iss_dest == AW'(i)) iss_ready_w = (cnt[i] != '1);
    end
  end

  assign fire          = bus.iss_valid && iss_ready_w && !bus.flush;
  assign bus.iss_ready = iss_ready_w;
  assign bus.rd_data   = rd_data_w;
  assign bus.rd_busy   = rd_busy_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(reset_value(i));
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.wb_en && (bus.wb_dest == AW'(i))) mem[i] <= bus.wb_value;
        if (bus.flush) begin
          cnt[i] <= '0;
        end else begin
          // A reservation and a release on the same register cancel out.
          case ({fire && (bus.iss_dest == AW'(i)),
                 bus.wb_en && (bus.wb_dest == AW'(i)) && (cnt[i] != '0)})
            2'b10:   cnt[i] <= cnt[i] + PEND_W'(1);
            2'b01:   cnt[i] <= cnt[i] - PEND_W'(1);
            default: cnt[i] <= cnt[i];
          endcase
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH),
      .PEND_W (PEND_W)
    ) u_port (
      .addr     (bus.rd_addr[k*AW +: AW]),
      .mem      (mem),
      .cnt      (cnt),
`ifdef REGFILE_WB_BYPASS_EN
      .wb_en    (bus.wb_en),
      .wb_dest  (bus.wb_dest),
      .wb_value (bus.wb_value),
`endif
      .data     (rd_data_w[k*WIDTH +: WIDTH]),
      .busy     (rd_busy_w[k])
    );
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the core register file: N read ports, one writeback port, and a per-register pending-write scoreboard.
- Sits between decode/issue and writeback.
  - Issue reserves a destination.
  - Writeback releases the reservation.
  - Read ports report both data and a "busy" hazard flag, so the hazard unit needs no separate scoreboard.
- Writes occur on the rising edge; the optional bypass makes a same-cycle writeback visible on reads.

Parameters:
- DEPTH, 15, number of architectural registers.
- WIDTH, 32, data bits per register.
- NUM_RD, 3, number of independent read ports.
- PEND_W, 2, width of each register's pending-write counter; max outstanding writes per register is 2^PEND_W-1.
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*WIDTH  packed read data, combinational from addresses.
- rd_busy  out  NUM_RD  1 = addressed register has pending count > 0.
- iss_valid  in  1  issue requests a reservation of iss_dest.
- iss_dest  in  AW  register to reserve.
- iss_ready  out  1  0 when iss_dest's counter is saturated or iss_dest >= DEPTH.
- wb_en  in  1  writeback strobe.
- wb_dest  in  AW  writeback register.
- wb_value  in  WIDTH  writeback data.
- flush  in  1  clears all pending counters (pipeline flush); register data is untouched.

Behaviour:
- Reset, when rst=1 at a rising edge:
  - mem[i] <= i (zero-extended to WIDTH) for every i.
  - All pending counters <= 0.
  - rst has priority over every other input, including a mid-cycle writeback.
- Outputs in the cycle after reset:
  - rd_data = address value (for in-range addresses).
  - rd_busy = 0.
  - iss_ready = 1 (for in-range iss_dest).
- Write:
  - Condition: wb_en=1 and wb_dest < DEPTH.
  - mem[wb_dest] <= wb_value at the rising edge; visible on rd_data from the next cycle (bypass macro undefined).
- Issue handshake:
  - A reservation fires when iss_valid & iss_ready; cnt[iss_dest] increments at the rising edge.
  - iss_ready is purely combinational from iss_dest and the counters; it is not registered.
- Release: wb_en=1 and cnt[wb_dest] > 0 -> decrement. At 0 the counter stays 0; no underflow, and the write still happens.
- Same register, same cycle, fire and release: counter unchanged (net 0).
- Different registers, same cycle: each counter updates independently.
- flush=1:
  - All counters <= 0.
  - An issue fire in the same cycle is dropped.
  - A writeback in the same cycle still writes data.
- Out-of-range addresses (>= DEPTH):
  - Reads return 0 with busy=0.
  - Writes are ignored.
  - Issue gives iss_ready=0.
- Read ports are fully independent. Identical addresses on several ports return identical data and busy.
- Latency:
  - Read: 0 cycles (combinational).
  - Write: 1 edge.
  - Scoreboard: 1 edge.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined, for port k where wb_en=1, wb_dest<DEPTH and rd_addr[k]==wb_dest:
  - rd_data[k] = wb_value in the same cycle.
  - rd_busy[k] = (cnt > 1), because the pending write being completed is treated as resolved.
- Undefined: rd_data is the stored value only; rd_busy = (cnt > 0).

Decomposition:
- Shared package regfile_pkg holds:
  - Default DEPTH/WIDTH/PEND_W constants.
  - Typedef for pending-counter type.
  - Constant for the reset-value function (index value).
- One natural sub-module: regfile_read_port, instantiated NUM_RD times via generate. It does address-range check, mux, optional bypass, and busy decode.

Test Plan:
- Reset then read ports 0..2 at addresses 3, 7, 14 -> rd_data = 3, 7, 14; rd_busy = 000; iss_ready = 1.
- wb_en=1, wb_dest=5, wb_value=32'hDEADBEEF, read addr 5:
  - Same cycle returns 5 without the macro, DEADBEEF with it.
  - Next cycle returns DEADBEEF in both builds.
- Issue reg 4 three times (PEND_W=2) -> cnt=3, iss_ready=0 on a 4th request for reg 4; writeback to reg 4 -> cnt=2, iss_ready=1, busy still 1.
- Simultaneous fire and writeback on reg 6 with cnt=1 -> cnt stays 1, data updated, busy=1.
- Counters on regs 1 and 2 = 2 and 1; assert flush together with an issue of reg 3 -> all counters 0, reg 3 not reserved, all busy=0.
- Write reg 9 = 32'h1234, then assert rst with a concurrent wb_en to reg 9 -> next cycle reg 9 reads 9, all counters 0.
